// File: rtl/var_clk_div.sv
// Variable-ratio clock divider with glitch-free divisor updates and en parking.
// Optional VAR_CLK_EDGE_CNT_EN adds an edge_cnt output counting rising edges of clk_out.
module var_clk_div #(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb
`ifdef VAR_CLK_EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    if (DIV_W == 0 || CNT_W == 0) begin : g_param_check
        $error("var_clk_div: DIV_W and CNT_W must be non-zero");
    end

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend;
    logic             active;
    logic             at_end;
    logic             toggle;
    logic             fall_tgl;
    logic             apply;

    // A high phase always runs to completion; a new divisor lands only at a phase boundary.
    always_comb begin
        active   = en | clk_out;
        at_end   = (cnt == cur_div);
        toggle   = active & at_end;
        fall_tgl = toggle & clk_out;
        apply    = busy & (fall_tgl | ~active);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            cur_div  <= DIV_W'(DIV_RST);
            pend     <= '0;
            busy     <= 1'b0;
            div_ack  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            div_ack  <= div_load;
            rise_stb <= toggle & ~clk_out;
            fall_stb <= fall_tgl;

            if (!active) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (at_end) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            if (apply) begin
                cur_div <= pend;
            end

            // A load on the apply cycle keeps the new value pending behind the applied one.
            if (div_load) begin
                pend <= div_in;
                busy <= 1'b1;
            end else if (apply) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef VAR_CLK_EDGE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (toggle & ~clk_out) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_var_clk_div.sv
// Scoreboard bench for var_clk_div: a phase-countdown reference model predicts every output cycle.
module tb_var_clk_div;

    localparam int unsigned DIV_W   = 4;
    localparam int unsigned DIV_RST = 0;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic             clk_out;
        logic             rise;
        logic             fall;
        logic             ack;
        logic             busy;
        logic [DIV_W-1:0] div;
        logic [CNT_W-1:0] edges;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [DIV_W-1:0] div_in = '0;
    logic             div_load = 1'b0;
    logic             div_ack;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
    logic             clk_out;
    logic             rise_stb;
    logic             fall_stb;
`ifdef VAR_CLK_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt;
`endif

    var_clk_div #(.DIV_W(DIV_W), .DIV_RST(DIV_RST), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .busy     (busy),
        .cur_div  (cur_div),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
`ifdef VAR_CLK_EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t sb[$];

    // Reference model: level of the divided clock and cycles left in the current half period.
    int m_level, m_left, m_div, m_pend, m_pv, m_edge;

    function automatic obs_t dut_obs();
        obs_t o;
        o.clk_out = clk_out;
        o.rise    = rise_stb;
        o.fall    = fall_stb;
        o.ack     = div_ack;
        o.busy    = busy;
        o.div     = cur_div;
`ifdef VAR_CLK_EDGE_CNT_EN
        o.edges   = edge_cnt;
`else
        o.edges   = '0;
`endif
        return o;
    endfunction

    function automatic void show_fail(string name, obs_t got, obs_t exp);
        $display("FAIL %s t=%0t got clk_out=%b rise=%b fall=%b ack=%b busy=%b cur_div=%0d edges=%0d | expected clk_out=%b rise=%b fall=%b ack=%b busy=%b cur_div=%0d edges=%0d",
                 name, $time, got.clk_out, got.rise, got.fall, got.ack, got.busy, got.div, got.edges,
                 exp.clk_out, exp.rise, exp.fall, exp.ack, exp.busy, exp.div, exp.edges);
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_div   = DIV_RST;
        m_pend  = 0;
        m_pv    = 0;
        m_edge  = 0;
        m_left  = m_div + 1;
    endtask

    task automatic model_step(input logic e, input logic l, input logic [DIV_W-1:0] d);
        obs_t x;
        int   rise = 0;
        int   fall = 0;
        if (!e && m_level == 0) begin
            if (m_pv != 0) begin
                m_div = m_pend;
                m_pv  = 0;
            end
            m_left = m_div + 1;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_level != 0) begin
                    fall    = 1;
                    m_level = 0;
                    if (m_pv != 0) begin
                        m_div = m_pend;
                        m_pv  = 0;
                    end
                end else begin
                    rise    = 1;
                    m_level = 1;
                    m_edge  = (m_edge + 1) % (1 << CNT_W);
                end
                m_left = m_div + 1;
            end
        end
        if (l) begin
            m_pend = int'(d);
            m_pv   = 1;
        end
        x.clk_out = (m_level != 0);
        x.rise    = (rise != 0);
        x.fall    = (fall != 0);
        x.ack     = l;
        x.busy    = (m_pv != 0);
        x.div     = DIV_W'(m_div);
`ifdef VAR_CLK_EDGE_CNT_EN
        x.edges   = CNT_W'(m_edge);
`else
        x.edges   = '0;
`endif
        sb.push_back(x);
    endtask

    // One clock of stimulus; inputs change 1 time unit after the active edge.
    task automatic cyc(input logic e, input logic l, input logic [DIV_W-1:0] d);
        en       = e;
        div_load = l;
        div_in   = d;
        @(posedge clk);
        model_step(e, l, d);
        #1;
    endtask

    task automatic check_reset(string name);
        obs_t z;
        z     = '0;
        z.div = DIV_W'(DIV_RST);
        n_cmp++;
        if (dut_obs() != z) begin
            n_bad++;
            show_fail(name, dut_obs(), z);
        end
    endtask

    // Asynchronous reset asserted between clock edges, checked before the next edge.
    task automatic mid_reset(string name);
        #1;
        sb.delete();
        rst_n = 1'b0;
        #1;
        check_reset(name);
        en       = 1'b0;
        div_load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_until_high(input int extra);
        int guard = 0;
        while (m_level == 0 && guard < 200) begin
            cyc(1'b1, 1'b0, '0);
            guard++;
        end
        n_cmp++;
        if (m_level == 0) begin
            n_bad++;
            $display("FAIL wait_high t=%0t got no rising phase within 200 cycles, expected one", $time);
        end
        repeat (extra) cyc(1'b1, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs() != e) begin
                n_bad++;
                show_fail("cycle", dut_obs(), e);
            end
        end
    end

    initial begin
        logic en_r;
        logic [DIV_W-1:0] d;
        model_reset();
        @(posedge clk);
        #1;
        check_reset("reset_initial");
        #1;
        rst_n = 1'b1;

        // Divide by 2 out of reset, then park and load 3.
        repeat (10) cyc(1'b1, 1'b0, '0);
        repeat (4)  cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, DIV_W'(3));
        repeat (3)  cyc(1'b0, 1'b0, '0);
        repeat (24) cyc(1'b1, 1'b0, '0);

        // Load 1 during a high phase.
        run_until_high(1);
        cyc(1'b1, 1'b1, DIV_W'(1));
        repeat (16) cyc(1'b1, 1'b0, '0);

        // Back-to-back loads 5 then 2 in one pending window.
        run_until_high(0);
        cyc(1'b1, 1'b1, DIV_W'(5));
        cyc(1'b1, 1'b1, DIV_W'(2));
        repeat (24) cyc(1'b1, 1'b0, '0);

        // Divisor 4, drop en one cycle after the rise, then re-enable.
        cyc(1'b1, 1'b1, DIV_W'(4));
        repeat (20) cyc(1'b1, 1'b0, '0);
        while (m_level != 0) cyc(1'b1, 1'b0, '0);
        run_until_high(1);
        repeat (12) cyc(1'b0, 1'b0, '0);
        repeat (24) cyc(1'b1, 1'b0, '0);

        // Maximum divisor, then divisor 0 at both extremes.
        cyc(1'b1, 1'b1, DIV_W'((1 << DIV_W) - 1));
        repeat (70) cyc(1'b1, 1'b0, '0);
        cyc(1'b1, 1'b1, DIV_W'(0));
        repeat (40) cyc(1'b1, 1'b0, '0);

        // Reset in the middle of a high phase at divisor 7.
        cyc(1'b1, 1'b1, DIV_W'(7));
        repeat (20) cyc(1'b1, 1'b0, '0);
        run_until_high(3);
        cyc(1'b1, 1'b1, DIV_W'(2));
        mid_reset("reset_mid_high");
        repeat (12) cyc(1'b1, 1'b0, '0);

        // Randomised traffic with en stretches and an extra mid-run reset.
        en_r = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            int r;
            if ($urandom_range(0, 24) == 0) en_r = ~en_r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      d = '0;
            else if (r == 1) d = DIV_W'((1 << DIV_W) - 1);
            else             d = DIV_W'($urandom_range(0, 5));
            cyc(en_r, ($urandom_range(0, 11) == 0), d);
            if (i == 1300) mid_reset("reset_random");
        end
        cyc(1'b0, 1'b0, '0);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
